main_memory_model: RTL and testbench

Synthesizable main-memory model that sits downstream of the cache controller on the `memoryIF` link and acts as its slave. It accepts one 512-bit cache-line read or write at a time and completes it after a fixed, parameterized latency. It fills its backing store with a known pattern after every reset, so that cache benches get deterministic miss data and back-pressure.

---
 rtl/mem_model_pkg.sv | 18 +
 rtl/memory_if.sv | 15 +
 rtl/mem_line_array.sv | 21 ++
 rtl/main_memory_model.sv | 120 ++++++++++++
 tb/tb_main_memory_model.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_model_pkg.sv
// Shared constants, FSM state type and fill-pattern helper for the main-memory model.
package mem_model_pkg;

    localparam int LINE_BITS      = 512;
    localparam int OFFSET_BITS    = 6;
    localparam int WORDS_PER_LINE = 16;

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} mem_state_t;

    // Post-reset content of line idx: every 32-bit word holds the line number.
    function automatic logic [LINE_BITS-1:0] init_line(input logic [31:0] idx);
        logic [LINE_BITS-1:0] line;
        line = '0;
        for (int w = 0; w < WORDS_PER_LINE; w++) line[w*32 +: 32] = idx;
        return line;
    endfunction

endpackage

// File: rtl/memory_if.sv
// Cache-controller to main-memory link; the memory model is the slave side.
interface memoryIF;
    import mem_model_pkg::*;

    logic [31:0]          addr;
    logic [LINE_BITS-1:0] wr_data;
    logic                 rw;
    logic                 valid;
    logic [LINE_BITS-1:0] rd_data;
    logic                 ready;

    modport slave  (input addr, wr_data, rw, valid, output rd_data, ready);
    modport master (output addr, wr_data, rw, valid, input rd_data, ready);

endinterface

// File: rtl/mem_line_array.sv
// Single-port line RAM: one write enable, registered read (read-before-write).
module mem_line_array
    import mem_model_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_W-1:0]     addr,
    input  logic [LINE_BITS-1:0] wdata,
    output logic [LINE_BITS-1:0] rdata
);

    logic [LINE_BITS-1:0] lines [2**IDX_W];

    always_ff @(posedge clk) begin
        if (we) lines[addr] <= wdata;
        rdata <= lines[addr];
    end

endmodule

// File: rtl/main_memory_model.sv
// Fixed-latency 512-bit line memory slave; refills itself with a known pattern after reset.
module main_memory_model
    import mem_model_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int LINE_IDX_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    memoryIF.slave      mem,
    output logic        init_done,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    mem_state_t state, state_next;

    logic [LINE_IDX_W-1:0] fill_idx, cap_idx, req_idx, ram_addr;
    logic [7:0]            cnt;
    logic                  cap_rw;
    logic [LINE_BITS-1:0]  cap_wdata, ram_wdata, ram_rdata, line_out;
    logic                  resp_ready, ram_we, access;
    logic                  unused_addr;

    assign req_idx     = mem.addr[OFFSET_BITS +: LINE_IDX_W];
    assign unused_addr = ^{mem.addr[OFFSET_BITS-1:0], mem.addr[31:OFFSET_BITS+LINE_IDX_W]};
    assign mem.ready   = resp_ready;
    assign mem.rd_data = line_out;

    // The access edge is E+LATENCY-1, so the master samples ready at E+LATENCY;
    // LATENCY=1 still needs one WAIT cycle, hence the <=1 test.
    always_comb begin
        state_next = state;
        access     = 1'b0;
        case (state)
            INIT: if (fill_idx == '1) state_next = IDLE;
            IDLE: if (mem.valid) state_next = WAIT;
            WAIT: if (cnt <= 8'd1) begin
                      state_next = RESP;
                      access     = 1'b1;
                  end
            RESP: state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    // In IDLE the RAM address follows the live request so the line is already
    // read out by the first WAIT edge.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = cap_idx;
        ram_wdata = cap_wdata;
        case (state)
            INIT: begin
                ram_we    = 1'b1;
                ram_addr  = fill_idx;
                ram_wdata = init_line(32'(fill_idx));
            end
            IDLE:    ram_addr = req_idx;
            WAIT:    ram_we   = access && cap_rw;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= INIT;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_idx   <= '0;
            cnt        <= '0;
            cap_idx    <= '0;
            cap_rw     <= 1'b0;
            cap_wdata  <= '0;
            resp_ready <= 1'b0;
            line_out   <= '0;
            init_done  <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            resp_ready <= access;
            case (state)
                INIT: begin
                    fill_idx <= fill_idx + LINE_IDX_W'(1);
                    if (fill_idx == '1) init_done <= 1'b1;
                end
                IDLE: if (mem.valid) begin
                    cap_idx   <= req_idx;
                    cap_rw    <= mem.rw;
                    cap_wdata <= mem.wr_data;
                    cnt       <= 8'(LATENCY - 1);
                end
                WAIT: begin
                    if (access) begin
                        if (cap_rw) begin
                            wr_count <= wr_count + 32'd1;
                        end else begin
                            rd_count <= rd_count + 32'd1;
                            line_out <= ram_rdata;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    mem_line_array #(.IDX_W(LINE_IDX_W)) u_lines (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_main_memory_model.sv
// Scoreboard bench: driver pushes expected responses, negedge monitor compares on ready.
module tb_main_memory_model;
    import mem_model_pkg::*;

    localparam int LAT = 4;
    localparam int IW  = 8;
    localparam int NL  = 2**IW;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init_done;
    logic [31:0] rd_count, wr_count;

    memoryIF mem_if();

    main_memory_model #(.LATENCY(LAT), .LINE_IDX_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (mem_if),
        .init_done (init_done),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    // Edge number since reset release: edge 1 is the first posedge with rst high.
    int cyc;
    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    typedef struct {
        logic [511:0] data;
        int           at_edge;
        logic [31:0]  rdc;
        logic [31:0]  wrc;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [511:0] model [NL];
    logic [511:0] last_rd;
    logic [31:0]  m_rdc, m_wrc;
    int           free_edge;

    function automatic logic [511:0] pat(input logic [31:0] w);
        return {16{w}};
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) model[i] = pat(32'(i));
        last_rd = '0;
        m_rdc   = '0;
        m_wrc   = '0;
        sb.delete();
    endtask

    // Called at a negedge. Acceptance is the next posedge, or the first edge the slave is idle.
    task automatic issue(input logic [31:0] a, input logic w, input logic [511:0] d,
                         input bit expect_resp, output int acc);
        int idx;
        mem_if.addr    = a;
        mem_if.rw      = w;
        mem_if.wr_data = d;
        mem_if.valid   = 1'b1;
        acc = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
        if (expect_resp) begin
            idx = int'(a[6 +: IW]);
            if (w) begin
                model[idx] = d;
                m_wrc++;
            end else begin
                last_rd = model[idx];
                m_rdc++;
            end
            sb.push_back('{last_rd, acc + LAT - 1, m_rdc, m_wrc});
        end
    endtask

    task automatic wait_ready(input bit hold);
        int k;
        k = 0;
        @(negedge clk);
        while (!mem_if.ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!mem_if.ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: no ready within %0d cycles", k);
        end else begin
            free_edge = cyc + 2;
        end
        if (!hold) mem_if.valid = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input bit hold);
        int acc;
        issue(a, 1'b0, '0, 1'b1, acc);
        wait_ready(hold);
    endtask

    task automatic wr(input logic [31:0] a, input logic [511:0] d, input bit hold);
        int acc;
        issue(a, 1'b1, d, 1'b1, acc);
        wait_ready(hold);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && (cyc == NL - 1 || cyc == NL))
            check("init_done", 512'(init_done), 512'(cyc == NL));
        if (rst && mem_if.ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready at edge %0d want none", cyc);
            end else begin
                e = sb.pop_front();
                check("ready_edge", 512'(cyc), 512'(e.at_edge));
                check("rd_data", mem_if.rd_data, e.data);
                check("rd_count", 512'(rd_count), 512'(e.rdc));
                check("wr_count", 512'(wr_count), 512'(e.wrc));
            end
        end
    end

    initial begin
        int           acc, k, gap;
        bit           hold;
        logic [511:0] d;

        mem_if.addr    = '0;
        mem_if.rw      = 1'b0;
        mem_if.wr_data = '0;
        mem_if.valid   = 1'b0;
        model_reset();
        free_edge = NL + 1;
        repeat (3) @(negedge clk);
        check("rst_ready", 512'(mem_if.ready), 512'(0));
        check("rst_rd_data", mem_if.rd_data, '0);
        check("rst_init_done", 512'(init_done), 512'(0));
        check("rst_rd_count", 512'(rd_count), 512'(0));
        check("rst_wr_count", 512'(wr_count), 512'(0));

        // Request already pending while INIT runs: accepted at the first IDLE edge.
        rst = 1'b1;
        rd(32'h0, 1'b0);
        repeat (2) @(negedge clk);
        rd(32'h140, 1'b0);
        @(negedge clk);
        wr(32'h140, pat(32'hDEADBEEF), 1'b0);
        rd(32'h17F, 1'b0);
        wr(32'h0001_4140, pat(32'hA5A5A5A5), 1'b0);
        @(negedge clk);
        rd(32'h140, 1'b0);
        @(negedge clk);
        rd(32'h40, 1'b1);
        rd(32'h80, 1'b1);
        rd(32'hC0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
            hold = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) wr($urandom, d, hold);
            else                          rd($urandom, hold);
            if (!hold) begin
                gap = $urandom_range(0, 3);
                repeat (gap) @(negedge clk);
            end
        end
        mem_if.valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset two cycles into a write: nothing commits, ready never pulses.
        issue(32'h1C0, 1'b1, pat(32'h1234_5678), 1'b0, acc);
        k = 0;
        while (cyc < acc + 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b0;
        mem_if.valid = 1'b0;
        #1;
        check("abort_ready", 512'(mem_if.ready), 512'(0));
        check("abort_wr_count", 512'(wr_count), 512'(0));
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        free_edge = NL + 1;
        rd(32'h1C0, 1'b0);
        repeat (4) @(negedge clk);
        check("sb_drained", 512'(sb.size()), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
